r22sdf_bitrev_reorder: RTL and testbench

- Output reorder buffer placed after the 64-pt R22SDF FFT pipeline.
- The FFT emits each frame in bit-reversed bin order; this block writes samples to bit-reversed addresses and reads them back linearly, so bins leave in natural order 0..N-1.
- Ping-pong storage of 2×fft_length complex words gives continuous streaming with one frame of buffering latency.

---
 rtl/r22sdf_pkg.sv | 36 +++
 rtl/r22sdf_dpram.sv | 36 +++
 rtl/r22sdf_bitrev_reorder.sv | 188 ++++++++++++++++++
 tb/tb_r22sdf_bitrev_reorder.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r22sdf_pkg.sv
// r22sdf_pkg: shared constants and helpers for the R22SDF output reorder buffer.
// Holds the read-FSM state encodings and the width/bit-reversal helper functions.
package r22sdf_pkg;

   // Ceiling log2, usable in constant expressions (port widths, localparams)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Reverse the low 'width' bits of 'value'; bits at and above 'width' come back as zero
   function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
      logic [15:0] r;
      logic [3:0]  idx;
      r = '0;
      for (int b = 0; b < 16; b++) begin
         if (b < width) begin
            idx        = 4'(width - 1 - b);
            r[4'(b)]   = value[idx];
         end
      end
      return r;
   endfunction

   localparam int DEF_FFT_LENGTH = 64;
   localparam int ADDR_W         = clog2(DEF_FFT_LENGTH);

   // Read-side FSM encodings
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/r22sdf_dpram.sv
// r22sdf_dpram: simple dual-port RAM, one write port and one registered read port.
// The shared clock enable freezes both ports; the read register holds between reads.
module r22sdf_dpram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Write port: storage is not reset, contents are only meaningful once written
   always_ff @(posedge i_clk) begin
      if (i_en && i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read port: reset to zero so the downstream data outputs start clean
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rd_data <= '0;
      end else if (i_en && i_rd_en) begin
         o_rd_data <= r_mem[i_rd_addr];
      end
   end

endmodule

// File: rtl/r22sdf_bitrev_reorder.sv
// r22sdf_bitrev_reorder: converts bit-reversed FFT output frames to natural bin order.
// Two-bank ping-pong RAM: writes land at bit-reversed addresses, reads sweep linearly.
// Optional build macro R22SDF_REORDER_IDX_EN adds the dout_idx natural-index output.
module r22sdf_bitrev_reorder
   import r22sdf_pkg::*;
#(
   parameter int data_resolution = 16,
   parameter int fft_length      = 64
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       sys_en,
   input  logic [data_resolution-1:0] din_r,
   input  logic [data_resolution-1:0] din_i,
   input  logic                       din_vld,
   input  logic                       din_sof,
   output logic [data_resolution-1:0] dout_r,
   output logic [data_resolution-1:0] dout_i,
   output logic                       dout_vld,
   output logic                       dout_sof,
   output logic                       dout_eof,
   output logic                       sync_err,
   output logic                       ovf
`ifdef R22SDF_REORDER_IDX_EN
   ,
   output logic [clog2(fft_length)-1:0] dout_idx
`endif
);

   localparam int            AW       = clog2(fft_length);
   localparam int            DW       = 2 * data_resolution;
   localparam logic [AW-1:0] LAST_IDX = AW'(fft_length - 1);

   logic [AW-1:0] r_wr_cnt;
   logic          r_wr_bank;
   logic [1:0]    r_bank_full;
   logic [0:0]    r_state;
   logic [AW-1:0] r_rd_cnt;
   logic          r_rd_bank;
   logic          r_vld;
   logic          r_sof;
   logic          r_eof;
   logic          r_sync_err;
   logic          r_ovf;

   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_wr_rev;
   logic          w_wr_last;
   logic          w_resync;
   logic          w_drop;
   logic [1:0]    w_set;
   logic          w_rd_en;
   logic          w_rd_last;
   logic [1:0]    w_clr;
   logic [AW:0]   w_wr_addr;
   logic [AW:0]   w_rd_addr;
   logic [DW-1:0] w_rd_data;

   // A start-of-frame always restarts at index 0, which also discards any partial frame
   assign w_wr_idx  = din_sof ? '0 : r_wr_cnt;
   assign w_wr_rev  = AW'(bitrev(16'(w_wr_idx), AW));
   assign w_wr_last = din_vld && (w_wr_idx == LAST_IDX);
   assign w_resync  = din_vld && din_sof && (r_wr_cnt != '0);
   assign w_drop    = w_wr_last && r_bank_full[r_wr_bank];
   assign w_set     = (w_wr_last && !w_drop) ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign w_wr_addr = {r_wr_bank, w_wr_rev};

   assign w_rd_en   = (r_state == ST_STREAM);
   assign w_rd_last = w_rd_en && (r_rd_cnt == LAST_IDX);
   assign w_clr     = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
   assign w_rd_addr = {r_rd_bank, r_rd_cnt};

   r22sdf_dpram #(
      .DATA_W (DW),
      .ADDR_W (AW + 1)
   ) u_ram (
      .i_clk     (sys_clk),
      .i_rst     (sys_rst),
      .i_en      (sys_en),
      .i_wr_en   (din_vld),
      .i_wr_addr (w_wr_addr),
      .i_wr_data ({din_r, din_i}),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Write counter and bank pointer; a dropped frame reuses the same bank next time
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (sys_en && din_vld) begin
         if (w_wr_last) begin
            r_wr_cnt <= '0;
            if (!w_drop) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end else begin
            r_wr_cnt <= w_wr_idx + AW'(1);
         end
      end
   end

   // Error pulses: resync abort and dropped completed frame
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sync_err <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (sys_en) begin
         r_sync_err <= w_resync;
         r_ovf      <= w_drop;
      end
   end

   // Bank-full flags: a set and a clear on the same bank in one cycle leaves it set
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_bank_full <= 2'b00;
      end else if (sys_en) begin
         r_bank_full <= (r_bank_full & ~w_clr) | w_set;
      end
   end

   // Read FSM: stream a full bank linearly, chaining into the other bank without a bubble
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= ST_IDLE;
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else if (sys_en) begin
         if (r_state == ST_IDLE) begin
            if (r_bank_full != 2'b00) begin
               r_state   <= ST_STREAM;
               r_rd_bank <= r_bank_full[0] ? 1'b0 : 1'b1;
               r_rd_cnt  <= '0;
            end
         end else begin
            r_rd_cnt <= r_rd_cnt + AW'(1);
            if (w_rd_last) begin
               if (r_bank_full[~r_rd_bank]) begin
                  r_rd_bank <= ~r_rd_bank;
                  r_rd_cnt  <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         end
      end
   end

   // Output flags travel alongside the RAM read register so they line up with the data
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_vld <= 1'b0;
         r_sof <= 1'b0;
         r_eof <= 1'b0;
      end else if (sys_en) begin
         r_vld <= w_rd_en;
         r_sof <= w_rd_en && (r_rd_cnt == '0);
         r_eof <= w_rd_last;
      end
   end

`ifdef R22SDF_REORDER_IDX_EN
   logic [AW-1:0] r_idx;

   // Natural bin index captured with each read so it tracks the data register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_idx <= '0;
      end else if (sys_en && w_rd_en) begin
         r_idx <= r_rd_cnt;
      end
   end

   assign dout_idx = r_idx;
`endif

   assign dout_r   = w_rd_data[DW-1:data_resolution];
   assign dout_i   = w_rd_data[data_resolution-1:0];
   assign dout_vld = r_vld;
   assign dout_sof = r_sof;
   assign dout_eof = r_eof;
   assign sync_err = r_sync_err;
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// tb_r22sdf_bitrev_reorder: directed self-checking bench for the reorder buffer (N=64).
// Input sample at position k of frame 'base' carries base*64+bitrev6(k), so bin b
// of that frame must come out as base*64+b (imaginary part negated).
module tb_r22sdf_bitrev_reorder;

   localparam int N = 64;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        sys_en;
   logic [15:0] din_r;
   logic [15:0] din_i;
   logic        din_vld;
   logic        din_sof;
   logic [15:0] dout_r;
   logic [15:0] dout_i;
   logic        dout_vld;
   logic        dout_sof;
   logic        dout_eof;
   logic        sync_err;
   logic        ovf;
`ifdef R22SDF_REORDER_IDX_EN
   logic [5:0]  dout_idx;
`endif

   typedef struct {
      logic [15:0] r;
      logic [15:0] i;
      logic        sof;
      logic        eof;
      int          cyc;
   } sample_t;

   sample_t outQ[$];
   int      compared    = 0;
   int      mismatched  = 0;
   int      actCycle    = 0;
   logic    enPrev      = 1'b0;
   int      syncCount   = 0;
   int      ovfCount    = 0;
   int      lastDriveCyc = 0;

   r22sdf_bitrev_reorder #(
      .data_resolution (16),
      .fft_length      (N)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .sys_en   (sys_en),
      .din_r    (din_r),
      .din_i    (din_i),
      .din_vld  (din_vld),
      .din_sof  (din_sof),
      .dout_r   (dout_r),
      .dout_i   (dout_i),
      .dout_vld (dout_vld),
      .dout_sof (dout_sof),
      .dout_eof (dout_eof),
      .sync_err (sync_err),
      .ovf      (ovf)
`ifdef R22SDF_REORDER_IDX_EN
      ,
      .dout_idx (dout_idx)
`endif
   );

   // 100 MHz clock
   always #5 sys_clk = ~sys_clk;

   // Count acting edges and remember whether the last edge acted
   always @(posedge sys_clk) begin
      enPrev <= sys_en && !sys_rst;
      if (sys_en && !sys_rst) actCycle <= actCycle + 1;
   end

   // Collect every freshly produced output sample and count error pulses
   always @(negedge sys_clk) begin
      if (!sys_rst && enPrev) begin
         if (dout_vld) outQ.push_back('{dout_r, dout_i, dout_sof, dout_eof, actCycle});
         if (sync_err) syncCount++;
         if (ovf) ovfCount++;
      end
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int rev6(input int k);
      int r;
      r = 0;
      for (int b = 0; b < 6; b++) begin
         if (k[b]) r = r | (1 << (5 - b));
      end
      return r;
   endfunction

   task automatic driveIdle();
      @(negedge sys_clk);
      din_vld = 1'b0;
      din_sof = 1'b0;
   endtask

   task automatic sendSample(input int k, input int base, input logic sof);
      int val;
      @(negedge sys_clk);
      val          = base * N + rev6(k);
      din_vld      = 1'b1;
      din_sof      = sof;
      din_r        = 16'(val);
      din_i        = 16'(-val);
      lastDriveCyc = actCycle;
   endtask

   task automatic sendFrame(input int base, input bit gapped);
      for (int k = 0; k < N; k++) begin
         sendSample(k, base, k == 0);
         if (gapped) driveIdle();
      end
      driveIdle();
   endtask

   task automatic waitOutputs(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while (outQ.size() < n && c < budget) begin
         @(negedge sys_clk);
         c++;
      end
      repeat (20) @(negedge sys_clk);
      compared++;
      if (outQ.size() != n) begin
         mismatched++;
         $display("[TB] FAIL %s count: got %0d samples, required %0d", tag, outQ.size(), n);
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      sys_en  = 1'b1;
      din_vld = 1'b0;
      din_sof = 1'b0;
      din_r   = '0;
      din_i   = '0;
      repeat (3) @(negedge sys_clk);
      compared++;
      if ({dout_r, dout_i, dout_vld, dout_sof, dout_eof, sync_err, ovf} !== 37'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got r=%h i=%h vld=%b sof=%b eof=%b se=%b ovf=%b, required all 0",
                  dout_r, dout_i, dout_vld, dout_sof, dout_eof, sync_err, ovf);
      end
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_single_frame();
      int s0, o0;
      s0 = syncCount;
      o0 = ovfCount;
      outQ.delete();
      sendFrame(0, 0);
      waitOutputs(N, 200, "single");
      for (int b = 0; b < N && b < outQ.size(); b++) begin
         compared++;
         if (outQ[b].r !== 16'(b) || outQ[b].i !== 16'(-b) ||
             outQ[b].sof !== (b == 0) || outQ[b].eof !== (b == N - 1)) begin
            mismatched++;
            $display("[TB] FAIL single_bin%0d: got r=%h i=%h sof=%b eof=%b, required r=%h i=%h",
                     b, outQ[b].r, outQ[b].i, outQ[b].sof, outQ[b].eof, 16'(b), 16'(-b));
         end
      end
      if (outQ.size() > 0) begin
         compared++;
         if (outQ[0].cyc - lastDriveCyc !== 3) begin
            mismatched++;
            $display("[TB] FAIL single_latency: got %0d cycles, required 3", outQ[0].cyc - lastDriveCyc);
         end
      end
      compared++;
      if (syncCount != s0 || ovfCount != o0) begin
         mismatched++;
         $display("[TB] FAIL single_errors: got sync=%0d ovf=%0d pulses, required 0",
                  syncCount - s0, ovfCount - o0);
      end
   endtask

   task automatic test_back_to_back();
      int s0, o0, f, b, v;
      s0 = syncCount;
      o0 = ovfCount;
      outQ.delete();
      for (int fr = 0; fr < 3; fr++) begin
         for (int k = 0; k < N; k++) sendSample(k, 2 + fr, k == 0);
      end
      driveIdle();
      waitOutputs(3 * N, 500, "b2b");
      for (int n = 0; n < outQ.size() && n < 3 * N; n++) begin
         f = n / N;
         b = n % N;
         v = (2 + f) * N + b;
         compared++;
         if (outQ[n].r !== 16'(v) || outQ[n].i !== 16'(-v) || outQ[n].sof !== (b == 0) ||
             outQ[n].eof !== (b == N - 1) || outQ[n].cyc !== outQ[0].cyc + n) begin
            mismatched++;
            $display("[TB] FAIL b2b_sample%0d: got r=%h i=%h sof=%b eof=%b cyc=%0d, required r=%h cyc=%0d",
                     n, outQ[n].r, outQ[n].i, outQ[n].sof, outQ[n].eof, outQ[n].cyc, 16'(v), outQ[0].cyc + n);
         end
      end
      compared++;
      if (syncCount != s0 || ovfCount != o0) begin
         mismatched++;
         $display("[TB] FAIL b2b_errors: got sync=%0d ovf=%0d pulses, required 0",
                  syncCount - s0, ovfCount - o0);
      end
   endtask

   task automatic test_gapped();
      int f, b, v;
      outQ.delete();
      sendFrame(5, 1);
      sendFrame(6, 1);
      waitOutputs(2 * N, 800, "gapped");
      for (int n = 0; n < outQ.size() && n < 2 * N; n++) begin
         f = n / N;
         b = n % N;
         v = (5 + f) * N + b;
         compared++;
         if (outQ[n].r !== 16'(v) || outQ[n].i !== 16'(-v) || outQ[n].sof !== (b == 0) ||
             outQ[n].eof !== (b == N - 1) || outQ[n].cyc !== outQ[f * N].cyc + b) begin
            mismatched++;
            $display("[TB] FAIL gapped_sample%0d: got r=%h i=%h sof=%b eof=%b cyc=%0d, required r=%h cyc=%0d",
                     n, outQ[n].r, outQ[n].i, outQ[n].sof, outQ[n].eof, outQ[n].cyc, 16'(v), outQ[f * N].cyc + b);
         end
      end
   endtask

   task automatic test_resync();
      int s0, v;
      s0 = syncCount;
      outQ.delete();
      for (int k = 0; k < 20; k++) sendSample(k, 7, k == 0);
      sendFrame(8, 0);
      waitOutputs(N, 200, "resync");
      repeat (80) @(negedge sys_clk);
      compared++;
      if (outQ.size() != N) begin
         mismatched++;
         $display("[TB] FAIL resync_total: got %0d samples, required %0d", outQ.size(), N);
      end
      for (int b = 0; b < N && b < outQ.size(); b++) begin
         v = 8 * N + b;
         compared++;
         if (outQ[b].r !== 16'(v) || outQ[b].i !== 16'(-v) || outQ[b].sof !== (b == 0)) begin
            mismatched++;
            $display("[TB] FAIL resync_bin%0d: got r=%h i=%h sof=%b, required r=%h i=%h",
                     b, outQ[b].r, outQ[b].i, outQ[b].sof, 16'(v), 16'(-v));
         end
      end
      compared++;
      if (syncCount - s0 != 1) begin
         mismatched++;
         $display("[TB] FAIL resync_pulses: got %0d sync_err pulses, required 1", syncCount - s0);
      end
   endtask

   task automatic test_stall();
      bit found;
      int v;
      found = 0;
      outQ.delete();
      sendFrame(9, 0);
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge sys_clk);
         if (dout_vld && dout_r == 16'(9 * N + 30)) found = 1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("[TB] FAIL stall_reach_bin30: got no bin 30, required bin 30 within 200 cycles");
      end
      sys_en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge sys_clk);
         compared++;
         if (dout_vld !== 1'b1 || dout_r !== 16'(9 * N + 30) || dout_i !== 16'(-(9 * N + 30))) begin
            mismatched++;
            $display("[TB] FAIL stall_hold%0d: got vld=%b r=%h i=%h, required vld=1 r=%h",
                     c, dout_vld, dout_r, dout_i, 16'(9 * N + 30));
         end
      end
      sys_en = 1'b1;
      waitOutputs(N, 200, "stall");
      for (int b = 0; b < N && b < outQ.size(); b++) begin
         v = 9 * N + b;
         compared++;
         if (outQ[b].r !== 16'(v) || outQ[b].i !== 16'(-v) || outQ[b].cyc !== outQ[0].cyc + b) begin
            mismatched++;
            $display("[TB] FAIL stall_bin%0d: got r=%h i=%h cyc=%0d, required r=%h cyc=%0d",
                     b, outQ[b].r, outQ[b].i, outQ[b].cyc, 16'(v), outQ[0].cyc + b);
         end
      end
   endtask

   task automatic test_reset_mid();
      int v;
      outQ.delete();
      for (int k = 0; k < N; k++) sendSample(k, 10, k == 0);
      for (int k = 0; k < 12; k++) sendSample(k, 11, k == 0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk);
         din_vld = 1'b1;
         din_r   = 16'(c + 100);
         din_i   = 16'(c + 200);
         compared++;
         if ({dout_r, dout_i, dout_vld, dout_sof, dout_eof, sync_err, ovf} !== 37'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_during%0d: got r=%h i=%h vld=%b sof=%b eof=%b se=%b ovf=%b, required all 0",
                     c, dout_r, dout_i, dout_vld, dout_sof, dout_eof, sync_err, ovf);
         end
      end
      sys_rst = 1'b0;
      din_vld = 1'b0;
      din_sof = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge sys_clk);
         compared++;
         if ({dout_vld, dout_sof, dout_eof, sync_err, ovf} !== 5'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_after%0d: got vld=%b sof=%b eof=%b se=%b ovf=%b, required all 0",
                     c, dout_vld, dout_sof, dout_eof, sync_err, ovf);
         end
      end
      outQ.delete();
      sendFrame(12, 0);
      waitOutputs(N, 200, "midreset");
      for (int b = 0; b < N && b < outQ.size(); b++) begin
         v = 12 * N + b;
         compared++;
         if (outQ[b].r !== 16'(v) || outQ[b].i !== 16'(-v) ||
             outQ[b].sof !== (b == 0) || outQ[b].eof !== (b == N - 1)) begin
            mismatched++;
            $display("[TB] FAIL midreset_bin%0d: got r=%h i=%h sof=%b eof=%b, required r=%h i=%h",
                     b, outQ[b].r, outQ[b].i, outQ[b].sof, outQ[b].eof, 16'(v), 16'(-v));
         end
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gapped();
      test_resync();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
